// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM encoding, default width.
package alu_pkg;

  localparam int ALU_DATA_WIDTH = 32;

  localparam logic [3:0] ALU_LUI   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_SLL   = 4'b0010;
  localparam logic [3:0] ALU_ADD   = 4'b0011;
  localparam logic [3:0] ALU_SRL   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0101;
  localparam logic [3:0] ALU_AND   = 4'b0110;
  localparam logic [3:0] ALU_NOR   = 4'b0111;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1001;
  localparam logic [3:0] ALU_MFHI  = 4'b1010;
  localparam logic [3:0] ALU_MFLO  = 4'b1011;
  localparam logic [3:0] ALU_SLT   = 4'b1100;
  localparam logic [3:0] ALU_SRA   = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } alu_state_e;

  // True for the opcodes that run on the iterative mul/div engine.
  function automatic logic is_multicycle_op(input logic [3:0] op);
    return (op == ALU_MULTU) || (op == ALU_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: shift-add unsigned multiply or restoring unsigned divide,
// one bit per cycle. done/hi/lo are presented combinationally during the final
// iteration so the owner can register them on the same edge.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_div,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  dbz
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  // acc_r: product high half / partial remainder; q_r: multiplier / quotient.
  logic [DATA_WIDTH-1:0] acc_r, q_r, b_r;
  logic [CNT_WIDTH-1:0]  cnt_r;
  logic                  run_r, is_div_r, dbz_r;

  logic [DATA_WIDTH:0]   sum_s, shifted_s, diff_s;
  logic [DATA_WIDTH-1:0] acc_next_s, q_next_s;

  // One iteration step of either algorithm.
  always_comb begin
    sum_s      = {1'b0, acc_r} + {1'b0, (q_r[0] ? b_r : {DATA_WIDTH{1'b0}})};
    shifted_s  = {acc_r, q_r[DATA_WIDTH-1]};
    diff_s     = shifted_s - {1'b0, b_r};
    acc_next_s = acc_r;
    q_next_s   = q_r;
    if (is_div_r) begin
      // A borrow into the top bit means the trial subtraction must be undone.
      if (diff_s[DATA_WIDTH] == 1'b0) begin
        acc_next_s = diff_s[DATA_WIDTH-1:0];
        q_next_s   = {q_r[DATA_WIDTH-2:0], 1'b1};
      end else begin
        acc_next_s = shifted_s[DATA_WIDTH-1:0];
        q_next_s   = {q_r[DATA_WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next_s = sum_s[DATA_WIDTH:1];
      q_next_s   = {sum_s[0], q_r[DATA_WIDTH-1:1]};
    end
  end

  // Operand latch and iteration state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r    <= {DATA_WIDTH{1'b0}};
      q_r      <= {DATA_WIDTH{1'b0}};
      b_r      <= {DATA_WIDTH{1'b0}};
      cnt_r    <= {CNT_WIDTH{1'b0}};
      run_r    <= 1'b0;
      is_div_r <= 1'b0;
      dbz_r    <= 1'b0;
    end else if (start && !run_r) begin
      acc_r    <= {DATA_WIDTH{1'b0}};
      q_r      <= a;
      b_r      <= b;
      cnt_r    <= {CNT_WIDTH{1'b0}};
      run_r    <= 1'b1;
      is_div_r <= is_div;
      dbz_r    <= (b == {DATA_WIDTH{1'b0}});
    end else if (run_r) begin
      acc_r <= acc_next_s;
      q_r   <= q_next_s;
      cnt_r <= cnt_r + CNT_WIDTH'(1);
      run_r <= (cnt_r != CNT_LAST);
    end else begin
      run_r <= 1'b0;
    end
  end

  // A zero divisor needs no special path: every trial subtraction succeeds,
  // giving an all-ones quotient and the dividend as remainder.
  assign done = run_r && (cnt_r == CNT_LAST);
  assign hi   = acc_next_s;
  assign lo   = q_next_s;
  assign dbz  = dbz_r;

endmodule

// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU: single-cycle ops with latency 1, MULTU/DIVU into
// HI/LO through the iterative engine with latency DATA_WIDTH+1.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = ALU_DATA_WIDTH,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  alu_data_o,
  output logic                   zero_o,
  output logic [DATA_WIDTH-1:0]  hi_o,
  output logic [DATA_WIDTH-1:0]  lo_o,
  output logic                   div_by_zero_o
);

  localparam int HALF = DATA_WIDTH / 2;

  alu_state_e state_r, next_state_s;

  logic                  busy_r, done_r, zero_r, dbz_r;
  logic [DATA_WIDTH-1:0] data_r, hi_r, lo_r;
  logic [DATA_WIDTH-1:0] result_s;
  logic                  accept_s, multi_s, eng_start_s;
  logic                  eng_done_s, eng_dbz_s;
  logic [DATA_WIDTH-1:0] eng_hi_s, eng_lo_s;

  assign accept_s    = start_i && (state_r == ST_IDLE);
  assign multi_s     = is_multicycle_op(alu_operation_i);
  assign eng_start_s = accept_s && multi_s;

  alu_muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (eng_start_s),
    .is_div (alu_operation_i == ALU_DIVU),
    .a      (a_i),
    .b      (b_i),
    .done   (eng_done_s),
    .hi     (eng_hi_s),
    .lo     (eng_lo_s),
    .dbz    (eng_dbz_s)
  );

  // Single-cycle datapath result.
  always_comb begin
    result_s = {DATA_WIDTH{1'b0}};
    case (alu_operation_i)
      ALU_LUI:  result_s = {b_i[HALF-1:0], {HALF{1'b0}}};
      ALU_OR:   result_s = a_i | b_i;
      ALU_SLL:  result_s = b_i << shamt_i;
      ALU_ADD:  result_s = a_i + b_i;
      ALU_SRL:  result_s = b_i >> shamt_i;
      ALU_SUB:  result_s = a_i - b_i;
      ALU_AND:  result_s = a_i & b_i;
      ALU_NOR:  result_s = ~(a_i | b_i);
      ALU_MFHI: result_s = hi_r;
      ALU_MFLO: result_s = lo_r;
      ALU_SLT:  result_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SRA:  result_s = $signed(b_i) >>> shamt_i;
      default:  result_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (alu_operation_i == ALU_MULTU)) begin
          next_state_s = ST_MUL;
        end else if (accept_s && (alu_operation_i == ALU_DIVU)) begin
          next_state_s = ST_DIV;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (eng_done_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output registers: result, flags, HI/LO and handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      data_r <= {DATA_WIDTH{1'b0}};
      zero_r <= 1'b0;
      hi_r   <= {DATA_WIDTH{1'b0}};
      lo_r   <= {DATA_WIDTH{1'b0}};
      dbz_r  <= 1'b0;
    end else begin
      busy_r <= (next_state_s != ST_IDLE);
      if (eng_done_s) begin
        done_r <= 1'b1;
        hi_r   <= eng_hi_s;
        lo_r   <= eng_lo_s;
        data_r <= eng_lo_s;
        zero_r <= (eng_lo_s == {DATA_WIDTH{1'b0}});
        dbz_r  <= (state_r == ST_DIV) ? eng_dbz_s : dbz_r;
      end else if (eng_start_s) begin
        done_r <= 1'b0;
        dbz_r  <= (alu_operation_i == ALU_DIVU) ? 1'b0 : dbz_r;
      end else if (accept_s) begin
        done_r <= 1'b1;
        data_r <= result_s;
        zero_r <= (result_s == {DATA_WIDTH{1'b0}});
      end else begin
        done_r <= 1'b0;
      end
    end
  end

  assign busy_o        = busy_r;
  assign done_o        = done_r;
  assign alu_data_o    = data_r;
  assign zero_o        = zero_r;
  assign hi_o          = hi_r;
  assign lo_o          = lo_r;
  assign div_by_zero_o = dbz_r;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle at the default 32-bit width.
module tb_alu_multicycle;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [3:0]  alu_operation_i;
  logic [31:0] a_i, b_i;
  logic [4:0]  shamt_i;
  logic        busy_o, done_o, zero_o, div_by_zero_o;
  logic [31:0] alu_data_o, hi_o, lo_o;

  int checks   = 0;
  int failures = 0;
  int lat, busy_n;

  alu_multicycle dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .alu_operation_i (alu_operation_i),
    .a_i             (a_i),
    .b_i             (b_i),
    .shamt_i         (shamt_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .alu_data_o      (alu_data_o),
    .zero_o          (zero_o),
    .hi_o            (hi_o),
    .lo_o            (lo_o),
    .div_by_zero_o   (div_by_zero_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    alu_operation_i = op;
    a_i             = a;
    b_i             = b;
    shamt_i         = sh;
  endtask

  // Present an op for one clock; returns at the negedge after the issuing edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    @(negedge clk);
    drive(op, a, b, sh);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    drive(4'b0000, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd7);
  endtask

  // Latency counted in negedges, 1 being the negedge right after issue.
  task automatic wait_done(output int l, output int bn);
    l  = 1;
    bn = 0;
    while (done_o !== 1'b1 && l < 100) begin
      if (busy_o === 1'b1) bn++;
      @(negedge clk);
      l++;
    end
    check("wait_done", {63'd0, done_o}, 64'd1);
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp, input logic exp_zero);
    issue(op, a, b, sh);
    check({tag, "_done"}, {63'd0, done_o}, 64'd1);
    check({tag, "_data"}, {32'd0, alu_data_o}, {32'd0, exp});
    check({tag, "_zero"}, {63'd0, zero_o}, {63'd0, exp_zero});
  endtask

  initial begin
    reset   = 1'b0;
    start_i = 1'b0;
    drive(4'b0000, 32'd0, 32'd0, 5'd0);
    repeat (3) @(negedge clk);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_data", {31'd0, zero_o, alu_data_o}, 64'd0);
    reset = 1'b1;

    // Single-cycle ops
    single("sub", ALU_SUB, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1);
    @(negedge clk);
    check("done_pulse", {63'd0, done_o}, 64'd0);
    check("data_hold", {32'd0, alu_data_o}, 64'd0);
    single("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1);
    single("sra", ALU_SRA, 32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0);
    single("srl", ALU_SRL, 32'd0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
    single("lui", ALU_LUI, 32'd0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0);
    single("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0);
    single("slt_no", ALU_SLT, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0, 1'b1);
    single("sll", ALU_SLL, 32'd0, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0);
    single("nor", ALU_NOR, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 32'hF0F0_FF0F, 1'b0);
    single("and", ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0, 32'h0F00_0F00, 1'b0);
    single("or", ALU_OR, 32'h1200_0034, 32'h0056_7800, 5'd0, 32'h1256_7834, 1'b0);
    single("op_e", 4'b1110, 32'd9, 32'd9, 5'd1, 32'd0, 1'b1);

    // MULTU
    issue(ALU_MULTU, 32'hFFFF_FFFF, 32'd2, 5'd0);
    check("mul_busy0", {63'd0, busy_o}, 64'd1);
    wait_done(lat, busy_n);
    check("mul_lat", 64'(lat), 64'd33);
    check("mul_busy_cycles", 64'(busy_n), 64'd32);
    check("mul_busy_end", {63'd0, busy_o}, 64'd0);
    check("mul_hilo", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);
    check("mul_data", {32'd0, alu_data_o}, 64'h0000_0000_FFFF_FFFE);
    single("mfhi", ALU_MFHI, 32'd0, 32'd0, 5'd0, 32'd1, 1'b0);
    single("mflo", ALU_MFLO, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFE, 1'b0);
    single("add_keep", ALU_ADD, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0);
    check("hilo_keep", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);

    // DIVU
    issue(ALU_DIVU, 32'd100, 32'd7, 5'd0);
    wait_done(lat, busy_n);
    check("div_lat", 64'(lat), 64'd33);
    check("div_hilo", {hi_o, lo_o}, {32'd2, 32'd14});
    check("div_dbz", {63'd0, div_by_zero_o}, 64'd0);
    issue(ALU_DIVU, 32'd5, 32'd0, 5'd0);
    wait_done(lat, busy_n);
    check("dbz_lat", 64'(lat), 64'd33);
    check("dbz_hilo", {hi_o, lo_o}, {32'd5, 32'hFFFF_FFFF});
    check("dbz_flag", {63'd0, div_by_zero_o}, 64'd1);

    // ADD while busy is ignored; ADD in the done cycle is accepted
    issue(ALU_MULTU, 32'd7, 32'd9, 5'd0);
    repeat (3) @(negedge clk);
    drive(ALU_ADD, 32'd1, 32'd1, 5'd0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("busy_ign_done", {63'd0, done_o}, 64'd0);
    check("busy_ign_busy", {63'd0, busy_o}, 64'd1);
    wait_done(lat, busy_n);
    check("busy_ign_lat", 64'(lat), 64'd29);
    check("busy_ign_hilo", {hi_o, lo_o}, 64'd63);
    check("busy_ign_data", {32'd0, alu_data_o}, 64'd63);
    drive(ALU_ADD, 32'd10, 32'd20, 5'd0);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("b2b_done", {63'd0, done_o}, 64'd1);
    check("b2b_data", {32'd0, alu_data_o}, 64'd30);
    check("b2b_busy", {63'd0, busy_o}, 64'd0);

    // Reset in the middle of DIVU
    issue(ALU_DIVU, 32'd1000, 32'd3, 5'd0);
    check("div_issue_clr_dbz", {63'd0, div_by_zero_o}, 64'd0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_hilo", {hi_o, lo_o}, 64'd0);
    check("mid_rst_out", {29'd0, busy_o, done_o, zero_o, alu_data_o}, 64'd0);
    repeat (2) @(negedge clk);
    check("mid_rst_nodone", {63'd0, done_o}, 64'd0);
    reset = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done_o !== 1'b0) check("post_rst_nodone", {63'd0, done_o}, 64'd0);
    end
    issue(ALU_MULTU, 32'd3, 32'd5, 5'd0);
    wait_done(lat, busy_n);
    check("post_rst_lat", 64'(lat), 64'd33);
    check("post_rst_hilo", {hi_o, lo_o}, 64'd15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
